logic_pipe_unit: RTL and testbench

Parametrised, pipelined two-operand bitwise logic unit that generalises the single-function gate blocks, such as the XNOR gate, into one WIDTH-bit datapath. A 3-bit opcode selects the function per beat. An optional accumulate mode folds a multi-beat packet into one result. Results go through a DEPTH-entry output FIFO with valid/ready handshakes on both sides, so the unit sits between any producer and consumer of the BASE_LOGIC family and absorbs back-pressure.

---
 rtl/logic_pipe_unit.sv | 167 ++++++++++++++++
 tb/tb_logic_pipe_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_pipe_unit.sv
// logic_pipe_unit
// Pipelined two-operand bitwise logic unit with an optional accumulate mode
// and a DEPTH-entry output FIFO.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   unit can accept a beat (FIFO not full)
//   in0, in1   operands A and B (WIDTH bits)
//   op         0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT in0, 7 pass in0
//   acc_en     beat belongs to an accumulate packet
//   in_last    final beat of an accumulate packet (ignored when acc_en=0)
//   out_valid  FIFO head valid
//   out_ready  consumer takes the head
//   out        result at FIFO head
//   out_count  number of beats folded into the head result
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer side is gated only by FIFO occupancy, so in_ready never
// depends combinationally on out_ready; out/out_count come straight from the
// FIFO storage and stay stable while out_valid && !out_ready.
module logic_pipe_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] out_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_accept;
  logic             w_pop;
  logic             w_push;
  logic [WIDTH-1:0] w_push_data;
  logic [CNT_W-1:0] w_push_cnt;
  logic [WIDTH-1:0] w_f;

  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [CNT_W-1:0] r_mem_cnt  [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;

  function automatic logic [WIDTH-1:0] f_logic(input logic [2:0] f_op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (f_op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a ^ b);
      3'd4:    r = ~(a & b);
      3'd5:    r = ~(a | b);
      3'd6:    r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  assign in_ready  = (r_count != (AW+1)'(DEPTH));
  assign out_valid = (r_count != '0);
  assign out       = r_mem_data[r_rd_ptr];
  assign out_count = r_mem_cnt[r_rd_ptr];

  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;

  // Inside an open packet the running accumulator replaces operand A.
  assign w_f = f_logic(op, (r_state == S_ACC) ? r_acc : in0, in1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_push_data = w_f;
    w_push_cnt  = CNT_W'(1);
    if (w_accept) begin
      if (!acc_en) begin
        // Single beat: emit it and abort any open packet without a result.
        w_push      = 1'b1;
        w_push_data = f_logic(op, in0, in1);
        w_push_cnt  = CNT_W'(1);
        w_state_nxt = S_IDLE;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            w_acc_nxt   = w_f;
            w_cnt_nxt   = CNT_W'(1);
            w_push      = in_last;
            w_push_cnt  = CNT_W'(1);
            w_state_nxt = in_last ? S_IDLE : S_ACC;
          end
          default: begin
            w_acc_nxt   = w_f;
            // Beat counter saturates rather than wrapping.
            w_cnt_nxt   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
            w_push      = in_last;
            w_push_cnt  = w_cnt_nxt;
            w_state_nxt = in_last ? S_IDLE : S_ACC;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_cnt[i]  <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_push_data;
        r_mem_cnt[r_wr_ptr]  <= w_push_cnt;
        r_wr_ptr             <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_pipe_unit.sv
module tb_logic_pipe_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int EW    = WIDTH + 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [2:0]       op;
  logic             acc_en;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] out_count;

  // Second instance with a 2-bit beat counter, fed the same stimulus.
  logic             s_in_ready;
  logic             s_out_valid;
  logic [WIDTH-1:0] s_out;
  logic [1:0]       s_out_count;

  int n_checks;
  int n_fail;
  int n_pops;

  logic [EW-1:0]    exp_q[$];
  logic [3:0]       tt [8];
  logic             m_open;
  logic [WIDTH-1:0] m_acc;
  int               m_cnt;
  logic [EW-1:0]    head;

  logic_pipe_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .op(op), .acc_en(acc_en), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_count(out_count)
  );

  logic_pipe_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in0(in0), .in1(in1), .op(op), .acc_en(acc_en), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out(s_out), .out_count(s_out_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each function is described by its 4-entry truth table indexed by {a,b}.
  initial begin
    tt[0] = 4'b1000; // AND
    tt[1] = 4'b1110; // OR
    tt[2] = 4'b0110; // XOR
    tt[3] = 4'b1001; // XNOR
    tt[4] = 4'b0111; // NAND
    tt[5] = 4'b0001; // NOR
    tt[6] = 4'b0011; // NOT a
    tt[7] = 4'b1100; // pass a
  end

  function automatic logic [WIDTH-1:0] model_f(input int f_op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic [3:0] t;
    t = tt[f_op];
    for (int k = 0; k < WIDTH; k++) r[k] = t[{a[k], b[k]}];
    return r;
  endfunction

  function automatic logic [31:0] clamp(input int c, input int m);
    return (c > m) ? m : c;
  endfunction

  task automatic model_push(input logic [WIDTH-1:0] d, input int c);
    exp_q.push_back({d, 16'(clamp(c, 65535))});
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_open = 1'b0;
    m_acc  = '0;
    m_cnt  = 0;
  endtask

  // Scoreboard: inputs only change just after a rising edge, so the values
  // seen at the falling edge are the ones the next rising edge will act on.
  always @(negedge clk) begin
    int occ;
    if (rst_n) begin
      occ = exp_q.size();
      check("out_valid", 32'(out_valid), 32'(occ != 0));
      check("in_ready", 32'(in_ready), 32'(occ != DEPTH));
      check("sat_out_valid", 32'(s_out_valid), 32'(occ != 0));
      check("sat_in_ready", 32'(s_in_ready), 32'(occ != DEPTH));
      if (out_valid && out_ready) n_pops++;
      if (occ != 0) begin
        head = exp_q[0];
        check("out_data", 32'(out), 32'(head[EW-1:16]));
        check("out_count", 32'(out_count), clamp(int'(head[15:0]), 255));
        check("sat_out_data", 32'(s_out), 32'(head[EW-1:16]));
        check("sat_out_count", 32'(s_out_count), clamp(int'(head[15:0]), 3));
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && occ != DEPTH) begin
        if (!acc_en) begin
          model_push(model_f(int'(op), in0, in1), 1);
          m_open = 1'b0;
          m_acc  = '0;
          m_cnt  = 0;
        end else begin
          if (!m_open) begin
            m_acc = model_f(int'(op), in0, in1);
            m_cnt = 1;
          end else begin
            m_acc = model_f(int'(op), m_acc, in1);
            m_cnt = m_cnt + 1;
          end
          if (in_last) begin
            model_push(m_acc, m_cnt);
            m_open = 1'b0;
          end else begin
            m_open = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [2:0] b_op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic b_acc, input logic b_last);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op       = b_op;
    in0      = a;
    in1      = b;
    acc_en   = b_acc;
    in_last  = b_last;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!got) check("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] tt_exp [8];
    int pops0;
    n_checks = 0;
    n_fail   = 0;
    n_pops   = 0;
    model_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in0       = '0;
    in1       = '0;
    op        = '0;
    acc_en    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Truth table against the published constants.
    tt_exp[0] = 8'hC0; tt_exp[1] = 8'hFC; tt_exp[2] = 8'h3C; tt_exp[3] = 8'hC3;
    tt_exp[4] = 8'h3F; tt_exp[5] = 8'h03; tt_exp[6] = 8'h0F; tt_exp[7] = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      send_beat(3'(i), 8'hF0, 8'hCC, 1'b0, 1'b0);
      check($sformatf("tt_valid_op%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("tt_data_op%0d", i), 32'(out), 32'(tt_exp[i]));
      check($sformatf("tt_count_op%0d", i), 32'(out_count), 32'd1);
    end
    idle_cycles(2);

    // Accumulate XOR: one result 0x0F with count 3.
    send_beat(3'd2, 8'h01, 8'h02, 1'b1, 1'b0);
    send_beat(3'd2, 8'h55, 8'h04, 1'b1, 1'b0);
    check("accx_no_early", 32'(out_valid), 32'd0);
    send_beat(3'd2, 8'hAA, 8'h08, 1'b1, 1'b1);
    check("accx_valid", 32'(out_valid), 32'd1);
    check("accx_data", 32'(out), 32'h0F);
    check("accx_count", 32'(out_count), 32'd3);
    idle_cycles(2);

    // Back-pressure: four fill the FIFO, beats 5 and 6 wait for space.
    out_ready = 1'b0;
    pops0 = n_pops;
    for (int i = 0; i < 4; i++) send_beat(3'(i), 8'(8'h11 * (i + 1)), 8'h3C, 1'b0, 1'b0);
    check("bp_full", 32'(in_ready), 32'd0);
    fork
      begin
        send_beat(3'd4, 8'h5A, 8'h0F, 1'b0, 1'b0);
        send_beat(3'd5, 8'hA5, 8'h0F, 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    idle_cycles(DEPTH + 3);
    check("bp_pops", 32'(n_pops - pops0), 32'd6);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Abort: open AND packet, then a single OR beat.
    pops0 = n_pops;
    send_beat(3'd0, 8'hF0, 8'hCC, 1'b1, 1'b0);
    send_beat(3'd1, 8'hF0, 8'hCC, 1'b0, 1'b0);
    check("abort_data", 32'(out), 32'hFC);
    check("abort_count", 32'(out_count), 32'd1);
    idle_cycles(3);
    check("abort_pops", 32'(n_pops - pops0), 32'd1);

    // Saturation: 5-beat packet, 8-bit counter reports 5, 2-bit reports 3.
    for (int i = 0; i < 5; i++) send_beat(3'd1, 8'h01, 8'(1 << i), 1'b1, 1'(i == 4));
    check("sat_data", 32'(out), 32'h1F);
    check("sat_count8", 32'(out_count), 32'd5);
    check("sat_count2", 32'(s_out_count), 32'd3);
    idle_cycles(2);

    // Simultaneous push and pop with DEPTH-1 entries queued.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) send_beat(3'd7, 8'(8'h20 + i), 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 3'd3;
    in0       = 8'h0F;
    in1       = 8'h0F;
    acc_en    = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pp_in_ready", 32'(in_ready), 32'd1);
    check("pp_head", 32'(out), 32'h21);
    out_ready = 1'b1;
    idle_cycles(DEPTH + 2);

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 99) < 70);
      op        = 3'($urandom_range(0, 7));
      in0       = 8'($urandom);
      in1       = 8'($urandom);
      acc_en    = 1'($urandom_range(0, 1));
      in_last   = 1'($urandom_range(0, 99) < 30);
      out_ready = 1'($urandom_range(0, 99) < 65);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle_cycles(DEPTH + 2);
    check("rand_drained", 32'(out_valid), 32'd0);

    // Async reset mid-packet with two results queued.
    out_ready = 1'b0;
    send_beat(3'd0, 8'h12, 8'h34, 1'b0, 1'b0);
    send_beat(3'd1, 8'h56, 8'h78, 1'b0, 1'b0);
    send_beat(3'd2, 8'h9A, 8'hBC, 1'b1, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out", 32'(out), 32'd0);
    check("arst_out_count", 32'(out_count), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_beat(3'd3, 8'hF0, 8'hCC, 1'b1, 1'b1);
    check("post_rst_data", 32'(out), 32'hC3);
    check("post_rst_count", 32'(out_count), 32'd1);
    idle_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
